// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; flush is a synchronous redirect.
// Ports: master = fetch/decode side (drives in_*, flush, out_ready),
//        slave  = queue side (drives in_ready, out_*, count).
interface inst_fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_pc4;
    logic [31:0]      out_inst;
    logic             out_is_ctrl;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_pc4, out_inst, out_is_ctrl, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_pc4, out_inst, out_is_ctrl, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular {PC, instruction} prefetch FIFO between fetch and decode; flushes on redirect.
// Latency: a pushed entry is visible at the output the cycle after the push edge (no bypass).
// Backpressure: in_ready drops only when full (from registered count); NOP bubble when empty.
// Ports: Clk rising-edge clock, Clr async active-high reset, bus = inst_fetch_queue_if.slave.
// Optional feature: define FETCHQ_PREDECODE_EN to store a per-entry branch/jump tag
// (beq/bne/j/jal) driving out_is_ctrl; otherwise out_is_ctrl is tied low.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                Clk,
    input  logic                Clr,
    inst_fetch_queue_if.slave   bus
);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             push;
    logic             pop;

    // Ready/valid come from registered occupancy only, so there is no
    // combinational path from out_ready back to in_ready.
    assign bus.in_ready  = (cnt != FULL_CNT);
    assign bus.out_valid = (cnt != '0);
    assign bus.count     = cnt;

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Pointer and occupancy state. flush wins over push/pop; Clr wins over all.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge Clk) begin
        if (push && !bus.flush) begin
            pc_mem[wr_ptr]   <= bus.in_pc;
            inst_mem[wr_ptr] <= bus.in_inst;
        end
    end

    assign bus.out_pc   = bus.out_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign bus.out_inst = bus.out_valid ? inst_mem[rd_ptr] : NOP_INST;
    // Empty reads as PC 0, so the +4 naturally yields 4; wraps mod 2^32.
    assign bus.out_pc4  = bus.out_pc + 32'd4;

`ifdef FETCHQ_PREDECODE_EN
    logic tag_mem [DEPTH];

    function automatic logic is_ctrl_op(input logic [5:0] op);
        return (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h03);
    endfunction

    always_ff @(posedge Clk) begin
        if (push && !bus.flush) begin
            tag_mem[wr_ptr] <= is_ctrl_op(bus.in_inst[31:26]);
        end
    end

    assign bus.out_is_ctrl = bus.out_valid & tag_mem[rd_ptr];
`else
    assign bus.out_is_ctrl = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised scoreboard bench for inst_fetch_queue against a queue-based reference model.
// Latency: model entries become visible the cycle after the accepting edge.
// Backpressure: model accepts only below DEPTH entries and pops only when non-empty.
module tb_inst_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic Clk = 1'b0;
    logic Clr;

    inst_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP_INST(32'h0)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    ent_t model[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic bit exp_ctrl(input logic [31:0] inst);
`ifdef FETCHQ_PREDECODE_EN
        logic [5:0] op;
        op = inst[31:26];
        return (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h03);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] w;
        logic [5:0]  ops [4];
        ops = '{6'h04, 6'h05, 6'h02, 6'h03};
        w = $urandom;
        if ($urandom_range(0, 2) == 0) w[31:26] = ops[$urandom_range(0, 3)];
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard. A falling Clr while Clk is high is a mid-cycle reset
    // release: the model is emptied and the reset state checked at once.
    // Otherwise, on each falling clock edge the DUT is compared against the model,
    // then the model absorbs the handshake that the next rising edge will take.
    always @(negedge Clk or negedge Clr) begin
        if (Clk === 1'b1) begin
            model.delete();
            chk("rst_count",     32'(bus.count),     32'd0);
            chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_inst",  bus.out_inst,       32'h0);
            chk("rst_out_pc",    bus.out_pc,         32'h0);
            chk("rst_out_pc4",   bus.out_pc4,        32'd4);
            chk("rst_is_ctrl",   32'(bus.out_is_ctrl), 32'd0);
        end else if (Clr === 1'b0) begin
            int  n;
            bit  do_push;
            bit  do_pop;
            ent_t e;
            n = model.size();
            chk("count",     32'(bus.count),     32'(n));
            chk("in_ready",  32'(bus.in_ready),  32'(n < DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
            if (n > 0) begin
                chk("out_pc",      bus.out_pc,   model[0].pc);
                chk("out_inst",    bus.out_inst, model[0].inst);
                chk("out_pc4",     bus.out_pc4,  model[0].pc + 32'd4);
                chk("out_is_ctrl", 32'(bus.out_is_ctrl), 32'(exp_ctrl(model[0].inst)));
            end else begin
                chk("empty_pc",      bus.out_pc,   32'h0);
                chk("empty_inst",    bus.out_inst, 32'h0);
                chk("empty_pc4",     bus.out_pc4,  32'd4);
                chk("empty_is_ctrl", 32'(bus.out_is_ctrl), 32'd0);
            end
            if (bus.flush) begin
                model.delete();
            end else begin
                do_push = bus.in_valid && (n < DEPTH);
                do_pop  = bus.out_ready && (n > 0);
                if (do_pop) void'(model.pop_front());
                if (do_push) begin
                    e.pc   = bus.in_pc;
                    e.inst = bus.in_inst;
                    model.push_back(e);
                end
            end
        end
    end

    // Inputs are changed 1 time unit after a rising edge and held for one cycle.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit rdy, input bit fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clr           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_inst   = 32'h0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        // Release reset mid-way through the first high phase.
        #7 Clr = 1'b0;
        @(posedge Clk);
        #1;

        // Fill with decode stalled; the fifth offer must be refused.
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), rnd_inst(), 1'b0, 1'b0);

        // Full with pop and push offered: pop only; next cycle push accepted.
        step(1'b1, 32'h14, rnd_inst(), 1'b1, 1'b0);
        step(1'b1, 32'h18, rnd_inst(), 1'b0, 1'b0);

        // Stream: one priming push then push+pop every cycle over several wraps.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h100, rnd_inst(), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 32'h104 + 32'(i * 4), rnd_inst(), 1'b1, 1'b0);

        // Flush at count 3 with a same-cycle push and pop, then push PC 0x40.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h20 + 32'(i * 4), rnd_inst(), 1'b0, 1'b0);
        step(1'b1, 32'h80, rnd_inst(), 1'b1, 1'b1);
        step(1'b1, 32'h40, rnd_inst(), 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Predecode tag and PC+4 wrap.
        step(1'b1, 32'h200, 32'h1000_0003, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h0000_0020, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, rnd_inst(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, rnd_inst(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end

        // Reset mid-operation with entries held, pulsed inside the high phase.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), rnd_inst(), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        Clr = 1'b1;
        #2 Clr = 1'b0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, rnd_inst(), 1'($urandom_range(0, 1)), 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
